scmp_useq_stack: RTL
====================

SCMP_USEQ_STACK -- requirements
Module: scmp_useq_stack

Interface
REQ-001 SHALL have parameter PC_W, default 8, microcode PC width.
REQ-002 SHALL have parameter COND_W, default 10, condition vector width.
REQ-003 SHALL have parameter STACK_D, default 4, return-stack depth, power of two, at least 2.
REQ-004 SHALL have parameter NEXT_W, default 4, width of the relative next-PC field.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 stall  input  1  holds all sequencer state when high.
REQ-008 op_pc  input  PC_W  decode target from opcode map.
REQ-009 cond_in  input  COND_W  raw condition bits.
REQ-010 cond_mask, cond_xor  input  COND_W each  current micro-instruction condition fields.
REQ-011 nextpc  input  NEXT_W  unsigned relative step; 0 means "go to fetch" (PC 0).
REQ-012 ctl_decode, ctl_ret, ctl_call, ctl_cjmp, ctl_cld  input  1 each  micro-instruction control bits.
REQ-013 clr_err  input  1  clears sticky error flags.
REQ-014 mc_pc  output  PC_W  current micro-PC (addresses external PLA/ROM).
REQ-015 cond  output  1  OR-reduce of ((cond_in XOR cond_xor) AND cond_mask), combinational.
REQ-016 ld_en  output  1  cond OR NOT ctl_cld; gates register loads.
REQ-017 depth  output  clog2(STACK_D)+1  current stack occupancy.
REQ-018 ovf, unf  output  1 each  sticky stack overflow / underflow flags.

Function
REQ-019 Next mc_pc SHALL be chosen by priority: ctl_decode -> op_pc; ctl_ret -> popped top; ctl_cjmp AND cond -> mc_pc+1; nextpc==0 -> 0; else mc_pc+nextpc.
REQ-020 All PC arithmetic SHALL be modulo 2^PC_W (wrap from max to low values, no flag).
REQ-021 ctl_call SHALL push mc_pc+1 (modulo 2^PC_W), independent of which next-PC branch is taken.
REQ-022 ctl_call with ctl_ret (no ctl_decode) SHALL take popped top as next PC and replace top with mc_pc+1; depth unchanged.
REQ-023 ctl_call with ctl_decode and ctl_ret SHALL behave as call+ret for the stack while mc_pc takes op_pc.
REQ-024 Push when depth==STACK_D (without simultaneous ret) SHALL leave stack and depth unchanged and set ovf.
REQ-025 Ret when depth==0 (without decode) SHALL force next mc_pc to 0, leave depth 0, set unf.
REQ-026 ovf/unf SHALL stay set until clr_err; clr_err in the same cycle as a new error leaves the flag set.
REQ-027 stall high SHALL freeze mc_pc, stack, depth and flags; cond and ld_en still track inputs.
REQ-028 Stack SHALL be LIFO; entries beyond depth are don't-care and never observable.
REQ-029 Sequencer SHALL be zero-latency: PC update visible on mc_pc the cycle after the controlling micro-instruction.

Reset
REQ-030 rst_n low SHALL asynchronously set mc_pc=0, depth=0, ovf=0, unf=0; stack contents need not be cleared.
REQ-031 Reset mid-call/ret SHALL discard the operation; first post-reset cycle fetches PC 0.
REQ-032 cond and ld_en SHALL remain combinational during reset.

Verification
REQ-033 Reset then nextpc=1 for 300 cycles (PC_W=8) -> mc_pc counts 0..255, wraps to 0, 1, ...; ovf=unf=0.
REQ-034 mc_pc=0x10, ctl_call with nextpc=3; then ctl_ret at 0x13 -> mc_pc 0x13 then 0x11; depth 1 then 0.
REQ-035 Five nested calls with STACK_D=4 -> depth saturates at 4, ovf=1 after fifth; four rets return in LIFO order; fifth ret -> mc_pc=0, unf=1; clr_err -> both clear.
REQ-036 cond_in=0x001, cond_mask=0x001, cond_xor=0, ctl_cjmp, nextpc=5 at mc_pc=0x20 -> next 0x21; with cond_xor=0x001 -> 0x25; ctl_cld=1 gives ld_en=1 then 0.
REQ-037 ctl_decode+ctl_ret+ctl_call at depth 2, op_pc=0x40, mc_pc=0x08 -> mc_pc=0x40, depth 2, top=0x09.
REQ-038 stall held 3 cycles during a call, then rst_n pulsed low mid-cycle -> state frozen under stall, then immediately mc_pc=0, depth=0.

Source files
------------

// File: rtl/scmp_useq_stack.sv
// Microcode sequencer: prioritized next-PC selection, call/return stack with
// sticky overflow/underflow flags, and combinational condition/load-enable logic.
module scmp_useq_stack #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned COND_W  = 10,
    parameter int unsigned STACK_D = 4,
    parameter int unsigned NEXT_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic [PC_W-1:0]              op_pc,
    input  logic [COND_W-1:0]            cond_in,
    input  logic [COND_W-1:0]            cond_mask,
    input  logic [COND_W-1:0]            cond_xor,
    input  logic [NEXT_W-1:0]            nextpc,
    input  logic                         ctl_decode,
    input  logic                         ctl_ret,
    input  logic                         ctl_call,
    input  logic                         ctl_cjmp,
    input  logic                         ctl_cld,
    input  logic                         clr_err,
    output logic [PC_W-1:0]              mc_pc,
    output logic                         cond,
    output logic                         ld_en,
    output logic [$clog2(STACK_D):0]     depth,
    output logic                         ovf,
    output logic                         unf
);

    localparam int unsigned SP_W    = $clog2(STACK_D);
    localparam int unsigned DEPTH_W = SP_W + 1;

    logic [PC_W-1:0]    stack_q [STACK_D];
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    top;
    logic [SP_W-1:0]    top_idx;
    logic               empty;
    logic               full;

    logic [PC_W-1:0]    pc_nxt;
    logic [DEPTH_W-1:0] depth_nxt;
    logic               wr_en;
    logic [SP_W-1:0]    wr_idx;
    logic               ovf_set;
    logic               unf_set;

    assign cond  = |((cond_in ^ cond_xor) & cond_mask);
    assign ld_en = cond | ~ctl_cld;

    assign pc_inc  = mc_pc + PC_W'(1);
    assign top_idx = SP_W'(depth - DEPTH_W'(1));
    assign top     = stack_q[top_idx];
    assign empty   = (depth == '0);
    assign full    = (depth == DEPTH_W'(STACK_D));

    // Next-PC priority mux and stack-operation decode
    always_comb begin
        pc_nxt    = mc_pc + PC_W'(nextpc);
        depth_nxt = depth;
        wr_en     = 1'b0;
        wr_idx    = SP_W'(depth);
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        if (ctl_decode) begin
            pc_nxt = op_pc;
        end else if (ctl_ret) begin
            pc_nxt = empty ? '0 : top;
        end else if (ctl_cjmp && cond) begin
            pc_nxt = pc_inc;
        end else if (nextpc == '0) begin
            pc_nxt = '0;
        end

        // Call+ret rewrites the top in place; an empty-stack ret only flags
        if (ctl_ret) begin
            if (empty) begin
                unf_set = 1'b1;
            end else if (ctl_call) begin
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else begin
                depth_nxt = depth - DEPTH_W'(1);
            end
        end else if (ctl_call) begin
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                wr_en     = 1'b1;
                depth_nxt = depth + DEPTH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_pc <= '0;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (!stall) begin
            mc_pc <= pc_nxt;
            depth <= depth_nxt;
            ovf   <= ovf_set | (ovf & ~clr_err);
            unf   <= unf_set | (unf & ~clr_err);
        end
    end

    // Stack storage is not reset; entries above depth are never read
    always_ff @(posedge clk) begin
        if (rst_n && !stall && wr_en) begin
            stack_q[wr_idx] <= pc_inc;
        end
    end

endmodule
